// File: rtl/sram_wmask_param.sv
// Parametrised single-port synchronous SRAM with per-lane write mask,
// 1- or 2-edge read latency, read-valid strobe and optional post-reset zero fill.
module sram_wmask_param #(
  parameter int WIDTH      = 160,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int NLANE      = 10,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1,
  parameter int WRITE_THRU = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [WIDTH-1:0]  D,
  input  logic [NLANE-1:0]  BWEN,
  output logic [WIDTH-1:0]  Q,
  output logic              QV,
  output logic              BUSY
);

  localparam int LW = WIDTH / NLANE;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic              clr_we;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              acc, in_rng, do_wr;
  logic [WIDTH-1:0]  old_word, merged;
  logic [WIDTH-1:0]  rd_word_p0;
  logic              vld_p0;
  logic [WIDTH-1:0]  out_word;
  logic              out_vld;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == S_CLEAR && ptr == ADDR_W'(DEPTH - 1)) state_nx = S_IDLE;
  end

  always_comb begin
    BUSY   = (state == S_CLEAR);
    clr_we = (state == S_CLEAR) && RESET_N;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N)    ptr <= '0;
    else if (clr_we) ptr <= ptr + 1'b1;
  end

  // Stage 0: request decode, array lookup and lane merge
  always_comb begin
    acc      = !BUSY && !CEN && RESET_N;
    in_rng   = (32'(A) < 32'(DEPTH));
    do_wr    = acc && !WEN && in_rng;
    old_word = in_rng ? mem[A] : '0;
    merged   = old_word;
    for (int l = 0; l < NLANE; l++) begin
      if (!BWEN[l]) merged[l*LW +: LW] = D[l*LW +: LW];
    end
    vld_p0     = acc && (WEN || (WRITE_THRU != 0));
    rd_word_p0 = WEN ? old_word : (in_rng ? merged : '0);
  end

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[ptr] <= '0;
    end else if (do_wr) begin
      for (int l = 0; l < NLANE; l++) begin
        if (!BWEN[l]) mem[A][l*LW +: LW] <= D[l*LW +: LW];
      end
    end
  end

  // Stage 1: optional extra register for the two-edge read latency
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] data_p1;
      logic             vld_p1;
      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= rd_word_p0;
        end
      end
      assign out_word = data_p1;
      assign out_vld  = vld_p1;
    end else begin : g_lat1
      assign out_word = rd_word_p0;
      assign out_vld  = vld_p0;
    end
  endgenerate

  // Output stage: Q holds between accepted results
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      Q  <= '0;
      QV <= 1'b0;
    end else begin
      QV <= out_vld;
      if (out_vld) Q <= out_word;
    end
  end

endmodule

// File: tb/tb_sram_wmask_param.sv
// Bench for sram_wmask_param: four configurations share one stimulus stream and
// are checked against a per-configuration behavioural memory model.
module tb_sram_wmask_param;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         CEN = 1'b1;
  logic         WEN = 1'b1;
  logic [3:0]   A = '0;
  logic [159:0] D = '0;
  logic [9:0]   BWEN = '1;
  logic [159:0] q [4];
  logic         qv [4];
  logic         busy [4];

  int checks = 0;
  int failures = 0;

  // configurations: default, two-edge latency, write-through, short depth
  int lat [4] = '{1, 2, 1, 1};
  int wt  [4] = '{0, 0, 1, 0};
  int dep [4] = '{16, 16, 16, 12};

  logic [159:0] mdl [4][16];
  int           clr_left [4];
  logic         pv [4];
  logic [159:0] pq [4];
  logic         ev [4];
  logic [159:0] eq [4];
  logic         eb [4];

  always #5 CLK = ~CLK;

  sram_wmask_param u0 (.CLK(CLK), .RESET_N(RESET_N), .CEN(CEN), .WEN(WEN), .A(A), .D(D),
                       .BWEN(BWEN), .Q(q[0]), .QV(qv[0]), .BUSY(busy[0]));
  sram_wmask_param #(.RD_LAT(2)) u1 (.CLK(CLK), .RESET_N(RESET_N), .CEN(CEN), .WEN(WEN),
                       .A(A), .D(D), .BWEN(BWEN), .Q(q[1]), .QV(qv[1]), .BUSY(busy[1]));
  sram_wmask_param #(.WRITE_THRU(1)) u2 (.CLK(CLK), .RESET_N(RESET_N), .CEN(CEN), .WEN(WEN),
                       .A(A), .D(D), .BWEN(BWEN), .Q(q[2]), .QV(qv[2]), .BUSY(busy[2]));
  sram_wmask_param #(.DEPTH(12), .ADDR_W(4)) u3 (.CLK(CLK), .RESET_N(RESET_N), .CEN(CEN),
                       .WEN(WEN), .A(A), .D(D), .BWEN(BWEN), .Q(q[3]), .QV(qv[3]),
                       .BUSY(busy[3]));

  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one request for one clock edge and advance the model expectations.
  task automatic step(input logic cen, input logic wen, input logic [3:0] a,
                      input logic [159:0] d, input logic [9:0] bwen);
    logic         rv;
    logic [159:0] rq;
    CEN = cen; WEN = wen; A = a; D = d; BWEN = bwen;
    for (int i = 0; i < 4; i++) begin
      if (!RESET_N) begin
        clr_left[i] = dep[i];
        pv[i] = 1'b0;
        ev[i] = 1'b0;
        eq[i] = '0;
        for (int k = 0; k < 16; k++) mdl[i][k] = '0;
      end else begin
        rv = 1'b0;
        rq = '0;
        if (clr_left[i] > 0) begin
          clr_left[i]--;
        end else if (!cen) begin
          if (!wen) begin
            if (int'(a) < dep[i])
              for (int l = 0; l < 10; l++)
                if (!bwen[l]) mdl[i][a][l*16 +: 16] = d[l*16 +: 16];
            if (wt[i] != 0) begin
              rv = 1'b1;
              rq = (int'(a) < dep[i]) ? mdl[i][a] : '0;
            end
          end else begin
            rv = 1'b1;
            rq = (int'(a) < dep[i]) ? mdl[i][a] : '0;
          end
        end
        if (lat[i] == 1) begin
          ev[i] = rv;
          if (rv) eq[i] = rq;
        end else begin
          ev[i] = pv[i];
          if (pv[i]) eq[i] = pq[i];
          pv[i] = rv;
          pq[i] = rq;
        end
      end
      eb[i] = (clr_left[i] > 0);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 4'd0, '0, '1);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    for (int s = 0; s < 3; s++) idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[i] !== '0 || qv[i] !== 1'b0 || busy[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset u%0d got q=%h qv=%b busy=%b exp q=0 qv=0 busy=1",
                 i, q[i], qv[i], busy[i]);
      end
    end
  endtask

  // Release reset, poke requests while busy, and measure the busy window.
  task automatic test_clear(input int pre_steps);
    int  cnt [4];
    logic any;
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = busy[i] ? 1 : 0;
    for (int s = 0; s < 40; s++) begin
      any = eb[0] || eb[1] || eb[2] || eb[3];
      if (!any) break;
      if (s < pre_steps) step(1'b0, 1'b0, 4'd2, rnd160(), '0);
      else if (s < 8)    step(1'b0, 1'b1, 4'd2, '0, '1);
      else               idle();
      for (int i = 0; i < 4; i++) begin
        if (busy[i]) cnt[i]++;
        checks++;
        if (qv[i] !== ev[i] || q[i] !== eq[i] || busy[i] !== eb[i]) begin
          failures++;
          $display("FAIL clear u%0d got qv=%b busy=%b q=%h exp qv=%b busy=%b q=%h",
                   i, qv[i], busy[i], q[i], ev[i], eb[i], eq[i]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != dep[i]) begin
        failures++;
        $display("FAIL busy_len u%0d got=%0d exp=%0d", i, cnt[i], dep[i]);
      end
    end
  endtask

  task automatic test_read_all();
    for (int a = 0; a < 18; a++) begin
      if (a < 16) step(1'b0, 1'b1, 4'(a), '0, '1);
      else        idle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qv[i] !== ev[i] || q[i] !== eq[i]) begin
          failures++;
          $display("FAIL read_all u%0d a=%0d got qv=%b q=%h exp qv=%b q=%h",
                   i, a, qv[i], q[i], ev[i], eq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    RESET_N = 1'b0;
    idle(); idle();
    test_clear(5);
  endtask

  task automatic test_mid_clear_abort();
    RESET_N = 1'b0;
    idle(); idle();
    RESET_N = 1'b1;
    for (int s = 0; s < 5; s++) idle();
    RESET_N = 1'b0;
    idle(); idle();
    test_clear(0);
  endtask

  task automatic test_masked_write();
    logic [159:0] lanes_exp;
    lanes_exp = {{9{16'hA5A5}}, 16'h0000};
    step(1'b0, 1'b0, 4'd3, {20{8'hA5}}, '0);
    step(1'b0, 1'b0, 4'd3, '0, 10'b1111111110);
    step(1'b0, 1'b1, 4'd3, '0, '1);
    checks++;
    if (qv[0] !== 1'b1 || q[0] !== lanes_exp) begin
      failures++;
      $display("FAIL masked_read got qv=%b q=%h exp qv=1 q=%h", qv[0], q[0], lanes_exp);
    end
    for (int s = 0; s < 2; s++) begin
      if (s == 1) idle();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qv[i] !== ev[i] || q[i] !== eq[i]) begin
          failures++;
          $display("FAIL masked u%0d got qv=%b q=%h exp qv=%b q=%h",
                   i, qv[i], q[i], ev[i], eq[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_qv = 0;
    for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 4'(a), 160'(a), '0);
    idle();
    for (int s = 0; s < 10; s++) begin
      if (s < 8) step(1'b0, 1'b1, 4'(s), '0, '1);
      else       idle();
      if (qv[1]) n_qv++;
      checks++;
      if (s >= 1 && s <= 8 && (qv[1] !== 1'b1 || q[1] !== 160'(s - 1))) begin
        failures++;
        $display("FAIL lat2_seq s=%0d got qv=%b q=%h exp qv=1 q=%0d", s, qv[1], q[1], s - 1);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qv[i] !== ev[i] || q[i] !== eq[i]) begin
          failures++;
          $display("FAIL b2b u%0d s=%0d got qv=%b q=%h exp qv=%b q=%h",
                   i, s, qv[i], q[i], ev[i], eq[i]);
        end
      end
    end
    checks++;
    if (n_qv != 8) begin
      failures++;
      $display("FAIL lat2_qv_count got=%0d exp=8", n_qv);
    end
  endtask

  task automatic test_write_thru();
    step(1'b0, 1'b0, 4'd5, 160'h1234, '0);
    checks++;
    if (qv[2] !== 1'b1 || q[2] !== 160'h1234 || qv[0] !== 1'b0) begin
      failures++;
      $display("FAIL write_thru got qv=%b q=%h plain_qv=%b exp qv=1 q=1234 plain_qv=0",
               qv[2], q[2], qv[0]);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (qv[i] !== ev[i] || q[i] !== eq[i]) begin
        failures++;
        $display("FAIL write_thru_after u%0d got qv=%b q=%h exp qv=%b q=%h",
                 i, qv[i], q[i], ev[i], eq[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [159:0] d11;
    d11 = rnd160();
    step(1'b0, 1'b0, 4'd11, d11, '0);
    step(1'b0, 1'b0, 4'd13, rnd160(), '0);
    step(1'b0, 1'b1, 4'd13, '0, '1);
    checks++;
    if (qv[3] !== 1'b1 || q[3] !== '0) begin
      failures++;
      $display("FAIL oor_read got qv=%b q=%h exp qv=1 q=0", qv[3], q[3]);
    end
    step(1'b0, 1'b1, 4'd11, '0, '1);
    checks++;
    if (qv[3] !== 1'b1 || q[3] !== d11) begin
      failures++;
      $display("FAIL oor_neighbour got qv=%b q=%h exp qv=1 q=%h", qv[3], q[3], d11);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (qv[i] !== ev[i] || q[i] !== eq[i]) begin
        failures++;
        $display("FAIL oor u%0d got qv=%b q=%h exp qv=%b q=%h", i, qv[i], q[i], ev[i], eq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] bw;
    for (int s = 0; s < 300; s++) begin
      bw = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom());
      step(($urandom_range(0, 3) == 0), 1'($urandom()), 4'($urandom()), rnd160(), bw);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qv[i] !== ev[i] || q[i] !== eq[i] || busy[i] !== eb[i]) begin
          failures++;
          $display("FAIL random u%0d s=%0d got qv=%b q=%h exp qv=%b q=%h",
                   i, s, qv[i], q[i], ev[i], eq[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear(8);
    test_read_all();
    test_masked_write();
    test_mid_clear_abort();
    test_read_all();
    test_back_to_back();
    test_write_thru();
    test_out_of_range();
    test_random();
    test_reset_mid_clear();
    test_read_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_wmask_param.md
Name: sram_wmask_param

Overview:
- Parametrised single-port synchronous SRAM model that succeeds the fixed 8x160 scratchpad macro model.
- Adds configurable width and depth, per-lane write masking, selectable read latency (1 or 2), and a read-valid strobe.
- Optionally clears the whole array after reset and can echo written data on Q (write-through).
- Used for activation, weight and psum buffers in the core and the synthesis partitions.

Parameters:
- WIDTH, 160: data word width in bits; must be divisible by NLANE.
- DEPTH, 16: number of words; any value from 2 to 2^ADDR_W.
- ADDR_W, 4: address width; 2^ADDR_W >= DEPTH is required.
- NLANE, 10: write-mask lanes; lane width LW = WIDTH/NLANE.
- RD_LAT, 1: read latency in clock edges; legal values are 1 and 2.
- CLR_ON_RST, 1: 1 = zero-fill the array after reset deasserts.
- WRITE_THRU, 0: 1 = a write also drives the merged word onto Q.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- CEN  in  1  chip enable, active low.
- WEN  in  1  write enable, active low; 1 = read when CEN=0.
- A  in  ADDR_W  word address.
- D  in  WIDTH  write data.
- BWEN  in  NLANE  lane write enables, active low; bit i covers D[i*LW +: LW].
- Q  out  WIDTH  read data, registered; holds its last value between reads.
- QV  out  1  one-cycle pulse marking a new value on Q.
- BUSY  out  1  clear sequence in progress; requests are ignored while high.

Behaviour:
- Reset (RESET_N=0 sampled at an edge):
  - Q=0, QV=0, RD_LAT=2 pipeline stage and its valid bit cleared.
  - Clear pointer=0. FSM goes to CLEAR if CLR_ON_RST=1, else IDLE.
  - BUSY is registered: 1 if CLR_ON_RST=1, else 0.
  - Array contents are not touched during reset itself.
- FSM CLEAR:
  - Each edge writes all-zero to array[ptr], then ptr increments.
  - After writing DEPTH-1 the FSM moves to IDLE and BUSY drops at that same edge.
  - Total: BUSY high for exactly DEPTH edges after reset release.
- Reset asserted mid-clear restarts the clear from ptr=0.
- While BUSY=1, CEN/WEN/A/D/BWEN are ignored: no writes, QV stays 0, Q is unchanged.
- FSM IDLE, per edge:
  - CEN=1: no operation; Q holds; QV=0 on the next cycle.
  - CEN=0, WEN=0 (write): for each lane i with BWEN[i]=0, array[A] lane i <= D lane i; other lanes keep their old value.
    - BWEN all 1: no array change (legal no-op).
    - WRITE_THRU=1: the merged word (old lanes + new lanes) goes to Q with RD_LAT latency and QV pulses.
    - WRITE_THRU=0: Q and QV are unaffected by writes.
  - CEN=0, WEN=1 (read):
    - RD_LAT=1: Q=array[A] after the same edge, QV=1 for that cycle.
    - RD_LAT=2: array[A] is captured into a stage register at edge n; Q and QV update at edge n+1.
- Back-to-back accesses:
  - Reads can be issued every cycle.
  - A read at cycle n+1 to an address written at cycle n returns the new merged data.
  - With RD_LAT=2 the pipeline is fully pipelined, with no bubbles.
- Out of range (A >= DEPTH): writes are dropped; reads return Q=0 with QV=1.
- Q never resets except via RESET_N. QV is high for exactly one cycle per accepted read (or write-through).
- Array is not initialised in simulation when CLR_ON_RST=0: reads before writes return X, and benches must not rely on them.

Test Plan:
- Clear sequence: defaults, RESET_N low 3 cycles then high -> BUSY=1 for exactly 16 cycles, then 0. Read of every address -> Q=0, QV pulse each.
- Reset mid-clear: reassert RESET_N after 5 clear cycles, then release -> BUSY high a full 16 cycles again, and all entries read 0.
- Masked write:
  - Write A=3, D=all 0xA5 bytes, BWEN=0.
  - Then write A=3, D=0, BWEN=10'b1111111110 (lane 0 enabled only).
  - Read A=3 -> lane 0 = 0x0000, lanes 1..9 = 0xA5A5. QV is high one cycle after the read edge.
- Latency: RD_LAT=2, reads issued to A=0..7 back-to-back (after writing D=A) -> Q=0..7 on consecutive cycles, each delayed 2 edges from issue, with QV continuously high for 8 cycles.
- Write-through and ignore:
  - WRITE_THRU=1: write A=5, D=0x1234 (full mask) -> Q=0x1234 and QV pulse after 1 edge.
  - A request issued while BUSY=1 -> no QV and no array change.
- Out of range: DEPTH=12, ADDR_W=4. Write A=13, then read A=13 -> Q=0, QV=1. Read A=11 -> unchanged prior data.
